// File: rtl/tmds_decoder.sv
// TMDS channel receive decoder: bitslip-driven word alignment, then data/control decode.
// Define TMDS_DECODER_STATS_EN to enable the relock_cnt lock-loss counter.
module tmds_decoder #(
  parameter int unsigned WINDOW      = 4096,
  parameter int unsigned LOCK_TOKENS = 64,
  parameter int unsigned SLIP_WAIT   = 8
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [9:0] tmds_in,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic [7:0] relock_cnt
);

  // win also times the WAIT state, so it must hold SLIP_WAIT as well.
  localparam int unsigned WinMax = (WINDOW > SLIP_WAIT + 1) ? WINDOW : SLIP_WAIT + 1;
  localparam int unsigned WinW   = (WinMax > 1) ? $clog2(WinMax) : 1;
  localparam int unsigned RunW   = $clog2(LOCK_TOKENS + 1);

  typedef enum logic [1:0] {StSearch, StSlip, StWait, StLocked} state_e;

  state_e            state_q, state_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              seen_q, seen_d;
  logic              reach, win_end;
  logic [2:0]        tok_in, tok_word;

  logic [9:0]        word_q;
  logic              gate_q;
  logic              de_q, de_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        ctrl_q, ctrl_d;

  // Returns {hit, ctrl value}.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    logic [2:0] r;
    case (w)
      10'b1101010100: r = 3'b100;
      10'b0010101011: r = 3'b101;
      10'b0101010100: r = 3'b110;
      10'b1010101011: r = 3'b111;
      default:        r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  assign tok_in   = token_lookup(tmds_in);
  assign tok_word = token_lookup(word_q);

  // State register.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSearch;
      win_q   <= '0;
      run_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      run_q   <= run_d;
      seen_q  <= seen_d;
    end
  end

  // Next state and counters.
  always_comb begin
    run_d = '0;
    if (state_q != StWait && tok_in[2]) begin
      run_d = (run_q == RunW'(LOCK_TOKENS)) ? run_q : run_q + RunW'(1);
    end
  end

  assign reach   = (run_d == RunW'(LOCK_TOKENS));
  assign win_end = (state_q != StWait) && (win_q == WinW'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSearch: begin
        if (reach) begin
          state_d = StLocked;
        end else if (win_end) begin
          state_d = StSlip;
        end
      end
      StSlip:   state_d = StWait;
      StWait: begin
        if (win_q == WinW'(SLIP_WAIT)) begin
          state_d = StSearch;
        end
      end
      StLocked: begin
        if (win_end && !(seen_q || reach)) begin
          state_d = StSearch;
        end
      end
      default:  state_d = StSearch;
    endcase
  end

  always_comb begin
    win_d  = (state_d != state_q || win_end) ? '0 : win_q + WinW'(1);
    seen_d = (state_q == StLocked && !win_end) ? (seen_q | reach) : 1'b0;
  end

  // Moore outputs straight from the state register.
  always_comb begin
    bitslip = (state_q == StSlip);
    locked  = (state_q == StLocked);
  end

  // Output stage gates on the state seen when the word was sampled.
  always_comb begin
    de_d   = 1'b0;
    data_d = '0;
    ctrl_d = '0;
    if (gate_q) begin
      if (tok_word[2]) begin
        ctrl_d = tok_word[1:0];
      end else begin
        de_d   = 1'b1;
        data_d = tmds_decode(word_q);
        ctrl_d = ctrl_q;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      gate_q <= 1'b0;
      de_q   <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      word_q <= tmds_in;
      gate_q <= (state_q == StLocked);
      de_q   <= de_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign de       = de_q;
  assign data_out = data_q;
  assign ctrl_out = ctrl_q;

`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] relock_q;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
    end else if (state_q == StLocked && state_d == StSearch && relock_q != 8'hFF) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: random traffic against a cycle-level behavioural model,
// plus alignment, lock-loss and reset scenarios.
module tb_tmds_decoder;

  localparam int unsigned WINDOW    = 4096;
  localparam int unsigned LOCK      = 64;
  localparam int unsigned SLIP_WAIT = 8;
  localparam int unsigned PERIOD    = WINDOW + SLIP_WAIT + 2;
`ifdef TMDS_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk_pix = 1'b0;
  logic       rst_n;
  logic [9:0] tmds_in;
  logic       bitslip, locked, de;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic [7:0] relock_cnt;

  tmds_decoder #(
    .WINDOW     (WINDOW),
    .LOCK_TOKENS(LOCK),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .tmds_in   (tmds_in),
    .bitslip   (bitslip),
    .locked    (locked),
    .de        (de),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .relock_cnt(relock_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  int n_checks = 0;
  int n_errors = 0;
  int n_tick   = 0;
  int last_tok = 0;

  // Model: phase 0 hunting, 1 slip pulse, 2 settling, 3 locked.
  int         m_phase, m_age, m_run, m_relock;
  bit         m_seen;
  logic [9:0] p_word;
  bit         p_gate;
  logic       e_slip, e_lock, e_de;
  logic [7:0] e_data;
  logic [1:0] e_ctrl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (tick %0d)", tag, got, exp, n_tick);
    end
  endtask

  function automatic int tok_of(input logic [9:0] w);
    for (int k = 0; k < 4; k++) begin
      if (tokens[k] == w) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] dec_of(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] r;
    d    = w[9] ? ~w[7:0] : w[7:0];
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] b, input bit xm, input bit inv);
    logic [7:0] q;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
    return {inv, xm, inv ? ~q : q};
  endfunction

  // Random encoding of b that is not a control token.
  function automatic logic [9:0] data_word(input logic [7:0] b);
    int         k0;
    logic [9:0] w;
    k0 = int'($urandom_range(0, 3));
    w  = enc(b, k0[0], k0[1]);
    for (int k = 0; k < 4; k++) begin
      w = enc(b, ((k0 + k) % 4) % 2 == 1, (k0 + k) % 4 >= 2);
      if (tok_of(w) < 0) return w;
    end
    return w;
  endfunction

  // Word seen by a deserializer whose boundary is o bits late on a periodic stream of w.
  function automatic logic [9:0] rot(input logic [9:0] w, input int o);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[(i + o) % 10];
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_run = 0; m_seen = 0; m_relock = 0;
    p_word = '0; p_gate = 0;
    e_slip = 0; e_lock = 0; e_de = 0; e_data = '0; e_ctrl = '0;
  endtask

  task automatic model_step(input logic [9:0] w);
    int t, nxt;
    bit full;
    if (!p_gate) begin
      e_de = 0; e_data = '0; e_ctrl = '0;
    end else if (tok_of(p_word) >= 0) begin
      e_de = 0; e_data = '0; e_ctrl = 2'(tok_of(p_word));
    end else begin
      e_de = 1; e_data = dec_of(p_word);
    end
    p_word = w;
    p_gate = (m_phase == 3);

    t = tok_of(w);
    if (m_phase == 2 || t < 0) m_run = 0;
    else if (m_run < int'(LOCK)) m_run++;
    full = (m_run == int'(LOCK));
    nxt  = m_phase;
    case (m_phase)
      0: if (full) nxt = 3; else if (m_age == int'(WINDOW) - 1) nxt = 1;
      1: nxt = 2;
      2: if (m_age == int'(SLIP_WAIT)) nxt = 0;
      default: begin
        if (m_age == int'(WINDOW) - 1) begin
          if (!(m_seen || full)) begin
            nxt = 0;
            if (m_relock < 255) m_relock++;
          end
          m_seen = 0;
        end else if (full) begin
          m_seen = 1;
        end
      end
    endcase
    if (nxt != m_phase || (m_age == int'(WINDOW) - 1 && m_phase != 2)) m_age = 0;
    else m_age++;
    m_phase = nxt;
    e_lock  = (m_phase == 3);
    e_slip  = (m_phase == 1);
  endtask

  task automatic tick(input logic [9:0] w);
    logic [20:0] got, exp;
    tmds_in = w;
    @(posedge clk_pix);
    model_step(w);
    if (tok_of(w) >= 0) last_tok = n_tick + 1;
    #1;
    n_tick++;
    got = {bitslip, locked, de, data_out, ctrl_out, relock_cnt};
    exp = {e_slip, e_lock, e_de, e_data, e_ctrl, STATS ? 8'(m_relock) : 8'h00};
    check_eq("outs", 32'(got), 32'(exp));
  endtask

  task automatic line(input bit rnd);
    for (int j = 0; j < 280; j++) tick(rnd ? tokens[$urandom_range(0, 3)] : tokens[0]);
    for (int j = 0; j < 1920; j++) tick(data_word(rnd ? 8'($urandom) : 8'hA5));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({bitslip, locked, de, data_out, ctrl_out, relock_cnt}), 32'h0);
  endtask

  initial begin
    int first_lock, fall, pulse, off;
    bit wide, prev, got_lock;
    int pulses[$];

    rst_n   = 1'b0;
    tmds_in = '0;
    model_reset();

    // Reset with random input words.
    repeat (4) begin
      tmds_in = 10'($urandom);
      @(posedge clk_pix);
      #1;
      check_all_zero("rst_outs");
    end
    check_eq("rst_bitslip", 32'(bitslip), 32'h0);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_de", 32'(de), 32'h0);
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_ctrl", 32'(ctrl_out), 32'h0);
    check_eq("rst_relock", 32'(relock_cnt), 32'h0);
    rst_n  = 1'b1;
    n_tick = 0;

    // Aligned 1080p line of 0xA5 pixels.
    first_lock = -1;
    for (int j = 0; j < 280; j++) begin
      tick(tokens[0]);
      if (locked && first_lock < 0) first_lock = n_tick;
      if (j == 100) begin
        check_eq("blank_ctrl", 32'(ctrl_out), 32'h0);
        check_eq("blank_de", 32'(de), 32'h0);
      end
    end
    check_eq("lock_cycle", 32'(first_lock), 32'(LOCK));
    for (int j = 0; j < 1920; j++) begin
      tick(data_word(8'hA5));
      if (j >= 2 && j % 480 == 7) begin
        check_eq("a5_data", 32'(data_out), 32'hA5);
        check_eq("a5_de", 32'(de), 32'h1);
      end
    end

    // Control tokens while locked; ctrl holds across following data.
    tick(tokens[3]);
    tick(tokens[1]);
    check_eq("tok11_ctrl", 32'(ctrl_out), 32'h3);
    check_eq("tok11_de", 32'(de), 32'h0);
    tick(data_word(8'h5A));
    check_eq("tok01_ctrl", 32'(ctrl_out), 32'h1);
    check_eq("tok01_de", 32'(de), 32'h0);
    tick(data_word(8'h81));
    check_eq("data_5a", 32'(data_out), 32'h5A);
    check_eq("ctrl_hold", 32'(ctrl_out), 32'h1);

    // Random lines keep the lock.
    repeat (3) line(1'b1);
    check_eq("still_locked", 32'(locked), 32'h1);

    // Data only: lock must drop, then slipping resumes one window later.
    fall  = -1;
    pulse = -1;
    for (int i = 0; i < int'(3 * WINDOW) + 64 && pulse < 0; i++) begin
      tick(data_word(8'($urandom)));
      if (fall < 0 && !locked) fall = n_tick;
      else if (fall >= 0 && bitslip) pulse = n_tick;
    end
    check_eq("loss_seen", 32'(fall >= 0), 32'h1);
    check_eq("loss_bound", 32'((fall - last_tok) <= int'(2 * WINDOW)), 32'h1);
    check_eq("relock_cnt", 32'(relock_cnt), STATS ? 32'h1 : 32'h0);
    check_eq("slip_after_loss", 32'(pulse - fall), 32'(WINDOW));

    // Reset while in WAIT.
    tick(data_word(8'h00));
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst_wait_now");
    repeat (3) begin
      @(posedge clk_pix);
      #1;
      check_all_zero("rst_wait_hold");
    end
    rst_n  = 1'b1;
    n_tick = 0;

    // Deserializer starts 3 bits late and moves one bit per bitslip pulse.
    off      = 3;
    wide     = 0;
    prev     = 0;
    got_lock = 0;
    for (int i = 0; i < int'(9 * PERIOD) && !got_lock; i++) begin
      tick(rot(tokens[0], off));
      if (bitslip) begin
        pulses.push_back(n_tick);
        if (prev) wide = 1;
        off = (off + 1) % 10;
      end
      prev = bitslip;
      if (locked) got_lock = 1;
    end
    check_eq("mis_locked", 32'(got_lock), 32'h1);
    check_eq("mis_pulses", 32'(pulses.size()), 32'd7);
    check_eq("mis_width", 32'(wide), 32'h0);
    if (pulses.size() > 0) begin
      check_eq("first_slip_after_rst", 32'(pulses[0] >= int'(WINDOW)), 32'h1);
    end
    for (int k = 1; k < pulses.size(); k++) begin
      check_eq("slip_spacing", 32'(pulses[k] - pulses[k-1]), 32'(PERIOD));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
